// File: rtl/mha_block_unpacker.sv
// Unpacks one wide word of TOTAL_MODULES square result blocks into a stream of
// block rows, one row per beat, with ready/valid on both sides.
module mha_block_unpacker #(
  parameter int WIDTH_OUT     = 16,
  parameter int BLOCK_SIZE    = 2,
  parameter int TOTAL_MODULES = 4,
  localparam int MOD_W = (TOTAL_MODULES > 1) ? $clog2(TOTAL_MODULES) : 1,
  localparam int ROW_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1
) (
  input  logic                                                 clk,
  input  logic                                                 rst_n,
  input  logic                                                 in_valid,
  output logic                                                 in_ready,
  input  logic [TOTAL_MODULES*BLOCK_SIZE*BLOCK_SIZE*WIDTH_OUT-1:0] in_data,
  input  logic                                                 in_last,
  output logic                                                 out_valid,
  input  logic                                                 out_ready,
  output logic [BLOCK_SIZE*WIDTH_OUT-1:0]                      out_data,
  output logic [MOD_W-1:0]                                     out_module,
  output logic [ROW_W-1:0]                                     out_row,
  output logic                                                 out_last
);

  localparam int BEATS     = TOTAL_MODULES * BLOCK_SIZE;
  localparam int CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int ROW_BITS  = BLOCK_SIZE * WIDTH_OUT;
  localparam int WORD_BITS = BEATS * ROW_BITS;

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_BUSY  = 1'b1;

  logic [0:0]           state_q;
  logic [WORD_BITS-1:0] buf_q;
  logic                 last_q;
  logic [CNT_W-1:0]     beat_q;
  logic [MOD_W-1:0]     mod_q;
  logic [ROW_W-1:0]     row_q;

  logic busy;
  logic final_beat;
  logic advance;
  logic accept;

  // Beat k is simply the k-th row-wide slice of the buffered word.
  logic [ROW_BITS-1:0] rows [BEATS];

  for (genvar i = 0; i < BEATS; i++) begin : g_rows
    assign rows[i] = buf_q[i*ROW_BITS +: ROW_BITS];
  end

  assign busy       = (state_q == S_BUSY);
  assign final_beat = busy && (beat_q == CNT_W'(BEATS - 1));
  assign advance    = busy && out_ready;
  // Reload is allowed in the cycle the last beat leaves, so words stream without a bubble.
  assign in_ready   = !busy || (final_beat && out_ready);
  assign accept     = in_valid && in_ready;

  assign out_valid  = busy;
  assign out_data   = rows[beat_q];
  assign out_module = mod_q;
  assign out_row    = row_q;
  assign out_last   = last_q && final_beat;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments throughout; the buffer is reset too so
      // out_data reads zero after reset rather than whatever the last word left.
      state_q <= S_EMPTY;
      buf_q   <= '0;
      last_q  <= 1'b0;
      beat_q  <= '0;
      mod_q   <= '0;
      row_q   <= '0;
    end else if (accept) begin
      state_q <= S_BUSY;
      buf_q   <= in_data;
      last_q  <= in_last;
      beat_q  <= '0;
      mod_q   <= '0;
      row_q   <= '0;
    end else if (advance) begin
      if (final_beat) begin
        state_q <= S_EMPTY;
        beat_q  <= '0;
        mod_q   <= '0;
        row_q   <= '0;
      end else begin
        beat_q <= beat_q + 1'b1;
        if (row_q == ROW_W'(BLOCK_SIZE - 1)) begin
          row_q <= '0;
          mod_q <= mod_q + 1'b1;
        end else begin
          row_q <= row_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mha_block_unpacker.sv
// Directed and random bench for mha_block_unpacker with an element-level scoreboard.
module tb_mha_block_unpacker;

  localparam int WIDTH_OUT     = 16;
  localparam int BLOCK_SIZE    = 2;
  localparam int TOTAL_MODULES = 4;
  localparam int BEATS         = TOTAL_MODULES * BLOCK_SIZE;
  localparam int BW            = BLOCK_SIZE * WIDTH_OUT;
  localparam int DW            = TOTAL_MODULES * BLOCK_SIZE * BLOCK_SIZE * WIDTH_OUT;
  localparam int MOD_W         = 2;
  localparam int ROW_W         = 1;

  typedef struct {
    logic [BW-1:0]    data;
    logic [MOD_W-1:0] m;
    logic [ROW_W-1:0] r;
    logic             last;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DW-1:0]    in_data = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [BW-1:0]    out_data;
  logic [MOD_W-1:0] out_module;
  logic [ROW_W-1:0] out_row;
  logic             out_last;

  int n_cmp = 0;
  int n_err = 0;
  int n_last_in = 0;
  int n_last_out = 0;
  beat_t sb[$];

  logic             hold_pend = 1'b0;
  logic [BW-1:0]    hold_data;
  logic [MOD_W-1:0] hold_mod;
  logic [ROW_W-1:0] hold_row;
  logic             hold_last;

  always #5 clk = ~clk;

  mha_block_unpacker #(
    .WIDTH_OUT    (WIDTH_OUT),
    .BLOCK_SIZE   (BLOCK_SIZE),
    .TOTAL_MODULES(TOTAL_MODULES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_module(out_module),
    .out_row   (out_row),
    .out_last  (out_last)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected beats built element by element from the (m,r,c) packing layout.
  task automatic push_word(input logic [DW-1:0] w, input logic lst);
    beat_t e;
    for (int m = 0; m < TOTAL_MODULES; m++) begin
      for (int r = 0; r < BLOCK_SIZE; r++) begin
        for (int c = 0; c < BLOCK_SIZE; c++)
          e.data[c*WIDTH_OUT +: WIDTH_OUT] = w[((m*BLOCK_SIZE + r)*BLOCK_SIZE + c)*WIDTH_OUT +: WIDTH_OUT];
        e.m    = MOD_W'(m);
        e.r    = ROW_W'(r);
        e.last = lst && (m == TOTAL_MODULES - 1) && (r == BLOCK_SIZE - 1);
        sb.push_back(e);
      end
    end
  endtask

  function automatic logic [DW-1:0] elem_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / WIDTH_OUT; i++) w[i*WIDTH_OUT +: WIDTH_OUT] = WIDTH_OUT'(i);
    return w;
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Monitor: scoreboard pops on output handshakes, pushes on input handshakes.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend <= 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_data", out_data, hold_data);
        check("hold_module", out_module, hold_mod);
        check("hold_row", out_row, hold_row);
        check("hold_last", out_last, hold_last);
      end
      hold_pend <= out_valid && !out_ready;
      hold_data <= out_data;
      hold_mod  <= out_module;
      hold_row  <= out_row;
      hold_last <= out_last;
      if (out_valid && out_ready) begin
        check("beat_expected", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          check("beat_data", out_data, sb[0].data);
          check("beat_module", out_module, sb[0].m);
          check("beat_row", out_row, sb[0].r);
          check("beat_last", out_last, sb[0].last);
          void'(sb.pop_front());
        end
        if (out_last) n_last_out <= n_last_out + 1;
      end
      if (in_valid && in_ready) begin
        push_word(in_data, in_last);
        if (in_last) n_last_in <= n_last_in + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(tag, sb.size(), 0);
  endtask

  initial begin
    int acc;
    int cyc;
    logic took;

    // Reset state
    repeat (3) tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_out_module", out_module, '0);
    check("rst_out_row", out_row, '0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);

    // Single word, numbered elements
    tick();
    in_valid = 1'b1; in_data = elem_word(); in_last = 1'b0; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("single_latency", out_valid, 1'b1);
    check("single_beat0_data", out_data, 32'h0001_0000);
    check("single_beat0_module", out_module, 2'd0);
    check("single_beat0_row", out_row, 1'b0);
    check("single_busy_in_ready", in_ready, 1'b0);
    drain("single_drain", 20);
    @(negedge clk);
    check("single_idle_valid", out_valid, 1'b0);
    check("single_idle_in_ready", in_ready, 1'b1);

    // Back-to-back words, no bubble
    tick();
    in_valid = 1'b1; in_data = rand_word(); in_last = 1'b0;
    @(negedge clk);
    check("b2b_first_accept", in_ready, 1'b1);
    tick();
    in_data = rand_word(); in_last = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      check("b2b_no_gap", out_valid, 1'b1);
      if (c < 16) check("b2b_in_ready", in_ready, c == 8);
      check("b2b_out_last", out_last, c == 16);
      tick();
      if (c == 8) begin
        in_valid = 1'b0; in_last = 1'b0;
      end
    end
    drain("b2b_drain", 4);
    @(negedge clk);
    check("b2b_idle_valid", out_valid, 1'b0);

    // Backpressure at beat 2
    tick();
    in_valid = 1'b1; in_data = elem_word(); in_last = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1'b1);
      check("bp_data", out_data, 32'h0005_0004);
      check("bp_module", out_module, 2'd1);
      check("bp_row", out_row, 1'b0);
      check("bp_in_ready", in_ready, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    drain("bp_drain", 20);

    // Input starvation
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("starve_valid", out_valid, 1'b0);
      check("starve_in_ready", in_ready, 1'b1);
      tick();
    end
    in_valid = 1'b1; in_data = rand_word(); in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    check("starve_new_word", out_valid, 1'b1);
    drain("starve_drain", 20);

    // Reset during beat 4
    tick();
    in_valid = 1'b1; in_data = rand_word(); in_last = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    sb.delete();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_valid", out_valid, 1'b0);
    check("mrst_module", out_module, '0);
    check("mrst_row", out_row, '0);
    check("mrst_data", out_data, '0);
    check("mrst_last", out_last, 1'b0);
    check("mrst_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b1; in_data = elem_word(); in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    check("mrst_restart_data", out_data, 32'h0001_0000);
    check("mrst_restart_module", out_module, 2'd0);
    check("mrst_restart_row", out_row, 1'b0);
    drain("mrst_drain", 20);

    // Random valid/ready traffic on both sides
    acc = 0; cyc = 0; took = 1'b0;
    while (acc < 1000 && cyc < 40000) begin
      tick();
      cyc++;
      if (took) in_valid = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && $urandom_range(0, 2) != 0) begin
        in_valid = 1'b1; in_data = rand_word(); in_last = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      took = in_valid && in_ready;
      if (took) acc++;
    end
    check("rand_words_accepted", acc, 1000);
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    drain("rand_drain", 200);
    tick();
    check("last_count", n_last_out, n_last_in);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mha_block_unpacker.md
Name: mha_block_unpacker

Overview:
- Output-side counterpart of the packed-block multiplication path in multi-head attention.
- Accepts one wide word holding TOTAL_MODULES result blocks, each BLOCK_SIZE×BLOCK_SIZE fixed-point elements, from the parallel K/Q/V matmul modules.
- Re-emits that word as a stream of block rows, one row of BLOCK_SIZE elements per beat, toward the write-back/BRAM side.
- Ready/valid on both sides; single-word buffer; back-to-back words without bubbles.

Parameters:
- WIDTH_OUT, 16, element width in bits (top_pkg TOP_WIDTH_OUT)
- BLOCK_SIZE, 2, block edge length (top_pkg TOP_BLOCK_SIZE)
- TOTAL_MODULES, 4, blocks per input word (top_pkg TOTAL_MODULES_K/Q/V)
- BEATS (derived localparam), TOTAL_MODULES*BLOCK_SIZE, output beats per input word
- CNT_W (derived localparam), clog2_safe(BEATS), beat counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  unpacker can accept a word
- in_data  in  TOTAL_MODULES*BLOCK_SIZE*BLOCK_SIZE*WIDTH_OUT  packed blocks
- in_last  in  1  word is last of a tile/sequence
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts beat
- out_data  out  BLOCK_SIZE*WIDTH_OUT  one block row
- out_module  out  clog2_safe(TOTAL_MODULES)  source module index of current beat
- out_row  out  clog2_safe(BLOCK_SIZE)  row within block of current beat
- out_last  out  1  final beat of a word whose in_last was set

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n: sampled only on rising clk.
- Reset values: out_valid=0, out_data=0, out_module=0, out_row=0, out_last=0, beat counter=0, buffer empty, in_ready=1 on the cycle after reset.
- Reset mid-word discards the buffered word and emits no further beats.
- Packing layout: element (m,r,c) sits at in_data bit offset ((m*BLOCK_SIZE+r)*BLOCK_SIZE+c)*WIDTH_OUT, WIDTH_OUT bits wide.
- Beat k (0..BEATS-1) carries in_data[k*BLOCK_SIZE*WIDTH_OUT +: BLOCK_SIZE*WIDTH_OUT], with out_module=k/BLOCK_SIZE and out_row=k%BLOCK_SIZE.
- Beat order: ascending k. Data bits pass unchanged; no arithmetic or saturation.
- States:
  - EMPTY: in_ready=1, out_valid=0. A handshake (in_valid&&in_ready) latches in_data/in_last and sets k=0. Go to BUSY; out_valid=1 the next cycle (latency 1).
  - BUSY: out_valid=1. On out_ready, k increments. out_last=buffered_last && (k==BEATS-1).
- in_ready = EMPTY || (BUSY && k==BEATS-1 && out_ready). Combinational from state and out_ready; no combinational path from in_valid.
- End of word: when the final beat completes and a new word is handshaken in the same cycle, stay BUSY, load the new word, set k=0. The next beat comes from the new word with no bubble. Otherwise go to EMPTY.
- Backpressure: while out_valid && !out_ready, out_data, out_module, out_row and out_last hold stable.
- out_valid never drops without a handshake, except on reset.
- in_data is ignored when !(in_valid&&in_ready).
- BEATS=1 (TOTAL_MODULES=1, BLOCK_SIZE=1): every accepted word yields exactly one beat; the same-cycle reload rule applies.
- Throughput: sustained 1 beat/cycle when in_valid and out_ready stay high; 1 input word per BEATS cycles.

Test Plan:
- Reset then single word: in_data elements numbered 0x0000..0x000F in packing order (element index as value), in_last=0, out_ready=1 -> 8 beats, out_data = {0x0001,0x0000}, {0x0003,0x0002}, … {0x000F,0x000E}. out_module/out_row go 0/0,0/1,1/0,…,3/1. out_last=0 throughout. First beat valid one cycle after the accept.
- Back-to-back: two words with in_valid held high and out_ready=1 -> 16 consecutive beats with no gap. in_ready pulses only on cycle 8 of the first word. Second word's in_last=1 -> out_last=1 only on beat 16.
- Backpressure: out_ready low for 3 cycles at beat 2 -> out_data={0x0005,0x0004} held stable, out_module=1, out_row=0, in_ready=0. Stream resumes in order with no loss or duplication.
- Input starvation: word accepted, in_valid low for 20 cycles after the last beat -> EMPTY, out_valid=0, in_ready=1 throughout. A new word is then accepted normally.
- Reset mid-word: rst_n=0 during beat 4 -> next cycle out_valid=0, counters=0, in_ready=1. The following word restarts at beat 0.
- Random: constrained-random valid/ready on both sides over 1000 words -> scoreboard sees an exact element-order match and out_last count equal to in_last count.
